// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the digit entry block.
package digit_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // 4 ID digits plus 6 password digits
    localparam int MAX_ENTRIES       = 10;
    localparam int MAX_DIGIT_DEFAULT = 9;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= 4'(MAX_ENTRIES)) begin
            return 4'(MAX_ENTRIES);
        end
        return v + 4'd1;
    endfunction

endpackage

// File: rtl/digit_entry_sync_2ff.sv
// Two-flop synchroniser for raw asynchronous inputs; clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/digit_entry.sv
// Debounced pushbutton digit entry with accept/reject strobes and a saturating entry count.
// Build option: define DIGIT_ENTRY_DEBOUNCE_EN to include the debounce counter (else N = 1).
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_DIGIT       = MAX_DIGIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_enter,
    input  logic [3:0] sw_digit,
    input  logic       clear,
    output logic       PasswordEnter,
    output logic [3:0] PasswordDigit,
    output logic [3:0] entry_count,
    output logic       digit_reject
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be within 1..65535");
    end

    logic       btn_s;
    logic [3:0] digit_s;
    logic       digit_ok;
    logic       strobe;
    state_t     state;
    state_t     state_next;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_enter),
        .q   (btn_s)
    );

    sync_2ff #(.WIDTH(4)) u_sync_digit (
        .clk (clk),
        .rst (rst),
        .d   (sw_digit),
        .q   (digit_s)
    );

    assign digit_ok = (int'(digit_s) <= MAX_DIGIT);

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    localparam logic [16:0] N_W = 17'(DEBOUNCE_CYCLES);

    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [16:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 17'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The strobe fires on the same edge that enters PRESSED, so the count
    // reaching N and the registered strobe coincide at edge N+2.
    always_comb begin
        state_next = state;
        strobe     = 1'b0;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
        cnt_next   = cnt;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
                    if (N_W <= 17'd1) begin
                        state_next = PRESSED;
                        strobe     = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = 16'd1;
                    end
`else
                    state_next = PRESSED;
                    strobe     = 1'b1;
`endif
                end
            end
            PRESS_WAIT: begin
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_inc >= N_W) begin
                    state_next = PRESSED;
                    strobe     = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc[15:0];
                end
`else
                state_next = IDLE;
`endif
            end
            PRESSED: begin
                if (!btn_s) begin
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
                    if (N_W <= 17'd1) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = 16'd1;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            RELEASE_WAIT: begin
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
                if (btn_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_inc >= N_W) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc[15:0];
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // clear wins over a coincident strobe, but the digit is still captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PasswordEnter <= 1'b0;
            digit_reject  <= 1'b0;
            PasswordDigit <= '0;
            entry_count   <= '0;
        end else begin
            PasswordEnter <= strobe && !clear && digit_ok;
            digit_reject  <= strobe && !clear && !digit_ok;
            if (strobe) begin
                PasswordDigit <= digit_s;
            end
            if (clear) begin
                entry_count <= '0;
            end else if (strobe && digit_ok) begin
                entry_count <= sat_inc(entry_count);
            end
        end
    end

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: presses push expected strobes, a forked monitor pops them.
module tb_digit_entry;

    localparam int N_CFG = 4;
    localparam int MAX_D = 9;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    localparam int N_EFF = N_CFG;
`else
    localparam int N_EFF = 1;
`endif

    typedef struct {
        bit         enter;
        logic [3:0] digit;
        logic [3:0] count;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_enter = 1'b0;
    logic [3:0] sw_digit = 4'd0;
    logic       clear = 1'b0;
    logic       PasswordEnter;
    logic [3:0] PasswordDigit;
    logic [3:0] entry_count;
    logic       digit_reject;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_count = 0;
    exp_t exp_q[$];

    digit_entry #(
        .DEBOUNCE_CYCLES (N_CFG),
        .MAX_DIGIT       (MAX_D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_enter     (btn_enter),
        .sw_digit      (sw_digit),
        .clear         (clear),
        .PasswordEnter (PasswordEnter),
        .PasswordDigit (PasswordDigit),
        .entry_count   (entry_count),
        .digit_reject  (digit_reject)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (PasswordEnter === 1'b1 || digit_reject === 1'b1) begin
                checks++;
                if (PasswordEnter === 1'b1 && digit_reject === 1'b1) begin
                    failures++;
                    $display("FAIL strobe_overlap cycle=%0d enter=1 reject=1, required at most one", cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe cycle=%0d enter=%b reject=%b, required none",
                             cyc, PasswordEnter, digit_reject);
                end else begin
                    e = exp_q.pop_front();
                    if (PasswordEnter !== e.enter || digit_reject !== !e.enter) begin
                        failures++;
                        $display("FAIL strobe_kind cycle=%0d enter=%b reject=%b, required enter=%b",
                                 cyc, PasswordEnter, digit_reject, e.enter);
                    end
                    checks++;
                    if (PasswordDigit !== e.digit) begin
                        failures++;
                        $display("FAIL strobe_digit got=%0d expected=%0d", PasswordDigit, e.digit);
                    end
                    checks++;
                    if (entry_count !== e.count) begin
                        failures++;
                        $display("FAIL strobe_count got=%0d expected=%0d", entry_count, e.count);
                    end
                    if (e.cyc >= 0) begin
                        checks++;
                        if (cyc !== e.cyc) begin
                            failures++;
                            $display("FAIL strobe_edge got=%0d expected=%0d", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    // Stimulus helper: clean press of digit d held for `hold` cycles, then a full release.
    task automatic press(input logic [3:0] d, input int hold);
        exp_t e;
        @(negedge clk);
        sw_digit  = d;
        btn_enter = 1'b1;
        e.enter = (int'(d) <= MAX_D);
        if (e.enter && model_count < 10) model_count++;
        e.digit = d;
        e.count = 4'(model_count);
        e.cyc   = cyc + N_EFF + 2;
        exp_q.push_back(e);
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        repeat (N_EFF + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        btn_enter = 1'b1;
        sw_digit  = 4'd5;
        repeat (3) @(negedge clk);
        checks++;
        if (PasswordEnter !== 1'b0) begin
            failures++;
            $display("FAIL reset_enter got=%b expected=0", PasswordEnter);
        end
        checks++;
        if (digit_reject !== 1'b0) begin
            failures++;
            $display("FAIL reset_reject got=%b expected=0", digit_reject);
        end
        checks++;
        if (PasswordDigit !== 4'd0) begin
            failures++;
            $display("FAIL reset_digit got=%0d expected=0", PasswordDigit);
        end
        checks++;
        if (entry_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d expected=0", entry_count);
        end
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_queue_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_strobes pending=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_press();
        press(4'd5, 20);
        test_queue_drained("press");
        checks++;
        if (entry_count !== 4'd1) begin
            failures++;
            $display("FAIL press_count got=%0d expected=1", entry_count);
        end
        checks++;
        if (PasswordDigit !== 4'd5) begin
            failures++;
            $display("FAIL press_digit got=%0d expected=5", PasswordDigit);
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        int   k;
        @(negedge clk);
        k = cyc;
        sw_digit  = 4'd7;
        btn_enter = 1'b1;
        // Without a debounce counter each synced high run is its own press.
        if (N_EFF == 1) begin
            e.enter = 1'b1;
            e.digit = 4'd7;
            model_count++;
            e.count = 4'(model_count);
            e.cyc   = k + 3;
            exp_q.push_back(e);
            model_count++;
            e.count = 4'(model_count);
            e.cyc   = k + 7;
            exp_q.push_back(e);
        end
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        btn_enter = 1'b0;
        repeat (N_EFF + 8) @(negedge clk);
        test_queue_drained("bounce");
        checks++;
        if (entry_count !== 4'(model_count)) begin
            failures++;
            $display("FAIL bounce_count got=%0d expected=%0d", entry_count, model_count);
        end
    endtask

    task automatic test_reject();
        press(4'd12, N_EFF + 3);
        test_queue_drained("reject");
        checks++;
        if (PasswordDigit !== 4'd12) begin
            failures++;
            $display("FAIL reject_digit got=%0d expected=12", PasswordDigit);
        end
        checks++;
        if (entry_count !== 4'(model_count)) begin
            failures++;
            $display("FAIL reject_count got=%0d expected=%0d", entry_count, model_count);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_count = 0;
        checks++;
        if (entry_count !== 4'd0) begin
            failures++;
            $display("FAIL sat_preclear got=%0d expected=0", entry_count);
        end
        for (int i = 0; i < 11; i++) begin
            press(4'd1, N_EFF + 3);
        end
        test_queue_drained("saturation");
        checks++;
        if (entry_count !== 4'd10) begin
            failures++;
            $display("FAIL sat_count got=%0d expected=10", entry_count);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_count = 0;
        checks++;
        if (entry_count !== 4'd0) begin
            failures++;
            $display("FAIL sat_clear got=%0d expected=0", entry_count);
        end
    endtask

    task automatic test_clear_on_strobe();
        press(4'd2, N_EFF + 3);
        @(negedge clk);
        sw_digit  = 4'd3;
        btn_enter = 1'b1;
        repeat (N_EFF + 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_count = 0;
        checks++;
        if (PasswordEnter !== 1'b0) begin
            failures++;
            $display("FAIL clrstrobe_enter got=%b expected=0", PasswordEnter);
        end
        checks++;
        if (entry_count !== 4'd0) begin
            failures++;
            $display("FAIL clrstrobe_count got=%0d expected=0", entry_count);
        end
        checks++;
        if (PasswordDigit !== 4'd3) begin
            failures++;
            $display("FAIL clrstrobe_digit got=%0d expected=3", PasswordDigit);
        end
        repeat (6) @(negedge clk);
        btn_enter = 1'b0;
        repeat (N_EFF + 4) @(negedge clk);
        test_queue_drained("clear_on_strobe");
    endtask

    task automatic test_rst_mid();
        press(4'd4, N_EFF + 3);
        @(negedge clk);
        sw_digit  = 4'd6;
        btn_enter = 1'b1;
        repeat (N_EFF + 1) @(negedge clk);
        rst = 1'b1;
        #1;
        model_count = 0;
        checks++;
        if (PasswordEnter !== 1'b0 || digit_reject !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_strobes enter=%b reject=%b expected 0 0", PasswordEnter, digit_reject);
        end
        checks++;
        if (PasswordDigit !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_digit got=%0d expected=0", PasswordDigit);
        end
        checks++;
        if (entry_count !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_count got=%0d expected=0", entry_count);
        end
        btn_enter = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (N_EFF + 6) @(negedge clk);
        test_queue_drained("rst_mid_abort");
        press(4'd8, N_EFF + 3);
        test_queue_drained("rst_mid_repress");
        checks++;
        if (entry_count !== 4'd1) begin
            failures++;
            $display("FAIL rstmid_repress_count got=%0d expected=1", entry_count);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_press();
        test_bounce();
        test_reject();
        test_saturation();
        test_clear_on_strobe();
        test_rst_mid();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles (N) needed to accept a press or a release; legal range 1..65535.
REQ-002 SHALL have parameter MAX_DIGIT, default 9, meaning the largest digit value accepted.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge system clock.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port btn_enter  in  1  raw, unsynchronised enter pushbutton, high = pressed.
REQ-006 SHALL have port sw_digit  in  4  raw digit switches.
REQ-007 SHALL have port clear  in  1  synchronous entry-count clear, driven from LogoutSignal or INIT.
REQ-008 SHALL have port PasswordEnter  out  1  single-cycle accepted-digit strobe to the authentication stage.
REQ-009 SHALL have port PasswordDigit  out  4  digit captured with the most recent accepted or rejected press.
REQ-010 SHALL have port entry_count  out  4  number of digits accepted since reset or clear.
REQ-011 SHALL have port digit_reject  out  1  single-cycle strobe for a press with digit > MAX_DIGIT.

Function
REQ-012 SHALL pass btn_enter and sw_digit through 2-flop synchronisers before any use.
REQ-013 SHALL implement FSM IDLE -> PRESS_WAIT -> PRESSED -> RELEASE_WAIT -> IDLE, driven by the synchronised button level.
REQ-014 IDLE: synced high -> PRESS_WAIT with counter = 1.
REQ-015 PRESS_WAIT: synced low -> IDLE with counter = 0; counter reaching N -> PRESSED.
REQ-016 PRESSED: SHALL emit exactly one strobe, then wait for synced low -> RELEASE_WAIT with counter = 1.
REQ-017 RELEASE_WAIT: synced high -> PRESSED with no new strobe; low for N cycles -> IDLE.
REQ-018 With btn_enter held stable, the strobe SHALL be high for exactly one cycle, starting at the (N+2)th rising edge after the first edge that samples btn_enter high.
REQ-019 A held button SHALL produce one strobe only; a bounce shorter than N cycles SHALL produce none.
REQ-020 On the strobe cycle, PasswordDigit SHALL load the synchronised sw_digit.
REQ-021 If that digit <= MAX_DIGIT, PasswordEnter SHALL pulse; otherwise digit_reject SHALL pulse instead. The two strobes are never high together.
REQ-022 entry_count SHALL increment by 1 on each PasswordEnter and saturate at 10, covering 4 ID digits plus 6 password digits.
REQ-023 Once saturated at 10, further presses SHALL still pulse PasswordEnter.
REQ-024 clear SHALL set entry_count to 0 on the next edge.
REQ-025 clear together with a strobe cycle SHALL suppress both strobes, leave entry_count at 0 and still update PasswordDigit; the FSM continues to PRESSED.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 rst SHALL asynchronously force: FSM = IDLE, counter = 0, synchronisers = 0, PasswordEnter = 0, digit_reject = 0, PasswordDigit = 0, entry_count = 0.
REQ-028 rst asserted mid-count SHALL abort the press with no strobe; after release a press needs a full N cycles again.

Configuration
REQ-029 Macro DIGIT_ENTRY_DEBOUNCE_EN SHALL control the debounce counter.
REQ-030 Defined: debounce counter present, behaviour as above.
REQ-031 Undefined: counter removed and N treated as 1, so the strobe starts at the 3rd edge, with synchroniser and edge detection only. Release still requires a synced low before the next strobe.

Structure
REQ-032 Package digit_entry_pkg SHALL hold the FSM state enum, MAX_ENTRIES = 10 and the default MAX_DIGIT = 9.
REQ-033 Sub-module sync_2ff, with a width parameter, SHALL provide the synchroniser and be instantiated for btn_enter and sw_digit.

Verification (N = 4)
REQ-034 Press with sw_digit = 5, held 20 cycles -> one PasswordEnter at edge 6, PasswordDigit = 5, entry_count = 1.
REQ-035 btn_enter high 3 cycles, low 1, high 2, then low -> no strobe, entry_count = 0.
REQ-036 Press with sw_digit = 12 -> digit_reject pulse, no PasswordEnter, PasswordDigit = 12, entry_count unchanged.
REQ-037 11 clean presses of digit 1 -> 11 PasswordEnter pulses, entry_count = 10 after the 10th; clear -> 0 next edge.
REQ-038 clear asserted on the strobe cycle -> no strobe, entry_count = 0. rst mid PRESS_WAIT -> all outputs 0 immediately, no strobe.
